// File: rtl/uart_fifo.sv
// uart_fifo: buffered full-duplex UART with TX/RX FIFOs, 3-sample majority RX and error flags
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   uart_tx_d/_dv/_dr           TX word, valid, ready (TX FIFO not full)
//   uart_rx_d/_dv/_dr           RX head word (fall-through), valid (RX FIFO not empty), consumer ready
//   parity_ok, framing_ok       status of the RX head word
//   rx_overflow, rx_break       sticky error flags, cleared by clr_errors
//   tx_level, rx_level          FIFO occupancies
//   uart_rx, uart_tx            serial pins, idle high
module uart_fifo_buf #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic push_ok, pop_ok;
  assign pop_ok = pop_i && level_q != '0;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push_i && (level_q != LW'(DEPTH) || pop_ok);
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_ok);
      rd_q <= rd_q + AW'(pop_ok);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  assign rdata_o = mem_q[rd_q];
  assign level_o = level_q;
endmodule

module uart_fifo #(
  parameter int    CLK_FREQ = 100000000,
  parameter int    BAUD_RATE = 115200,
  parameter int    NR_BITS = 8,
  parameter string PARITY = "NONE",
  parameter int    STOP_BITS = 1,
  parameter int    FIFO_DEPTH = 16,
  localparam int   LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NR_BITS-1:0] uart_tx_d,
  input  logic               uart_tx_dv,
  output logic               uart_tx_dr,
  output logic [NR_BITS-1:0] uart_rx_d,
  output logic               uart_rx_dv,
  input  logic               uart_rx_dr,
  output logic               parity_ok,
  output logic               framing_ok,
  output logic               rx_overflow,
  output logic               rx_break,
  input  logic               clr_errors,
  output logic [LW-1:0]      tx_level,
  output logic [LW-1:0]      rx_level,
  input  logic               uart_rx,
  output logic               uart_tx
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int HALF = BIT_CLKS / 2;
  localparam int CW = $clog2(BIT_CLKS);
  localparam int BW = $clog2(NR_BITS);
  localparam bit PAR_EN = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");

  if (BIT_CLKS < 4) begin : g_bad_baud
    $error("uart_fifo: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_st_t;

  logic [NR_BITS-1:0] tx_head;
  logic tx_pop;
  logic [NR_BITS+1:0] rx_head, rx_wdata;
  logic rx_push, rx_pop, rx_full;

  uart_fifo_buf #(.W(NR_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst_n(rst_n), .push_i(uart_tx_dv && uart_tx_dr), .pop_i(tx_pop),
    .wdata_i(uart_tx_d), .rdata_o(tx_head), .level_o(tx_level)
  );
  uart_fifo_buf #(.W(NR_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(rx_pop),
    .wdata_i(rx_wdata), .rdata_o(rx_head), .level_o(rx_level)
  );

  assign uart_tx_dr = tx_level != LW'(FIFO_DEPTH);
  assign uart_rx_dv = rx_level != '0;
  assign rx_pop = uart_rx_dv && uart_rx_dr;
  assign rx_full = rx_level == LW'(FIFO_DEPTH);
  // head fields are forced to their idle values while the FIFO is empty
  assign uart_rx_d = uart_rx_dv ? rx_head[NR_BITS-1:0] : '0;
  assign parity_ok = !uart_rx_dv || rx_head[NR_BITS];
  assign framing_ok = !uart_rx_dv || rx_head[NR_BITS+1];

  // TX
  tx_st_t tst_q, tst_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] tbit_q, tbit_d;
  logic [NR_BITS-1:0] tsh_q, tsh_d;
  logic tpar_q, tpar_d, txo_q, txo_d, t_end;

  assign t_end = tcnt_q == CW'(BIT_CLKS - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tst_q <= T_IDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tsh_q <= '0;
      tpar_q <= 1'b0;
      txo_q <= 1'b1;
    end else begin
      tst_q <= tst_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q <= tsh_d;
      tpar_q <= tpar_d;
      txo_q <= txo_d;
    end

  always_comb begin
    tst_d = tst_q;
    tcnt_d = tst_q == T_IDLE ? tcnt_q : t_end ? '0 : tcnt_q + CW'(1);
    tbit_d = tbit_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    tx_pop = 1'b0;
    case (tst_q)
      T_IDLE: tx_pop = tx_level != '0;
      T_START: if (t_end) begin
        tst_d = T_DATA;
        tbit_d = '0;
      end
      T_DATA: if (t_end) begin
        tsh_d = tsh_q >> 1;
        tbit_d = tbit_q + BW'(1);
        if (tbit_q == BW'(NR_BITS - 1)) begin
          tst_d = PAR_EN ? T_PAR : T_STOP;
          tbit_d = '0;
        end
      end
      T_PAR: if (t_end) tst_d = T_STOP;
      T_STOP: if (t_end) begin
        tbit_d = tbit_q + BW'(1);
        if (tbit_q == BW'(STOP_BITS - 1)) begin
          tst_d = T_IDLE;
          tx_pop = tx_level != '0;
        end
      end
      default: tst_d = T_IDLE;
    endcase
    // popping from IDLE or the last stop bit starts the next frame with no gap
    if (tx_pop) begin
      tst_d = T_START;
      tcnt_d = '0;
      tsh_d = tx_head;
      tpar_d = ^tx_head ^ PAR_ODD;
    end
  end

  // the line is registered, so it follows the state one clock later
  always_comb
    txo_d = tst_q == T_START ? 1'b0 : tst_q == T_DATA ? tsh_q[0] : tst_q == T_PAR ? tpar_q : 1'b1;

  assign uart_tx = txo_q;

  // RX
  rx_st_t rst_q, rst_d;
  logic s1_q, s2_q;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] rbit_q, rbit_d;
  logic [NR_BITS-1:0] rsh_q, rsh_d;
  logic [1:0] smp_q, smp_d;
  logic rv_q, rv_d, rpok_q, rpok_d, ovf_q, ovf_d, brk_q, brk_d;
  logic rxd, r_end, maj, cur;

  assign rxd = s2_q;
  assign r_end = rcnt_q == CW'(BIT_CLKS - 1);
  assign maj = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxd) | (smp_q[0] & rxd);
  // the third sample may coincide with the bit's last clock, so use the live vote then
  assign cur = rcnt_q == CW'(HALF + 1) ? maj : rv_q;
  assign rx_wdata = {cur, rpok_q, rsh_q};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      rst_q <= R_IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q <= '0;
      smp_q <= '0;
      rv_q <= 1'b1;
      rpok_q <= 1'b1;
      ovf_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      s1_q <= uart_rx;
      s2_q <= s1_q;
      rst_q <= rst_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q <= rsh_d;
      smp_q <= smp_d;
      rv_q <= rv_d;
      rpok_q <= rpok_d;
      ovf_q <= ovf_d;
      brk_q <= brk_d;
    end

  always_comb begin
    rst_d = rst_q;
    rcnt_d = r_end ? '0 : rcnt_q + CW'(1);
    rbit_d = rbit_q;
    rsh_d = rsh_q;
    smp_d = (rcnt_q == CW'(HALF - 1) || rcnt_q == CW'(HALF)) ? {smp_q[0], rxd} : smp_q;
    rv_d = rcnt_q == CW'(HALF + 1) ? maj : rv_q;
    rpok_d = rpok_q;
    rx_push = 1'b0;
    case (rst_q)
      // the clock that first sees the low line counts as clock 0 of the start bit
      R_IDLE: if (!rxd) begin
        rst_d = R_START;
        rcnt_d = CW'(1);
      end
      R_START: if (r_end) begin
        rst_d = cur ? R_IDLE : R_DATA;
        rbit_d = '0;
        rpok_d = 1'b1;
      end
      R_DATA: if (r_end) begin
        rsh_d = {cur, rsh_q[NR_BITS-1:1]};
        rbit_d = rbit_q + BW'(1);
        if (rbit_q == BW'(NR_BITS - 1)) rst_d = PAR_EN ? R_PAR : R_STOP;
      end
      R_PAR: if (r_end) begin
        rpok_d = ((^rsh_q) ^ cur) == PAR_ODD;
        rst_d = R_STOP;
      end
      R_STOP: if (r_end) begin
        rx_push = 1'b1;
        rst_d = cur ? R_IDLE : R_WAIT;
      end
      R_WAIT: if (rxd) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
    ovf_d = clr_errors ? 1'b0 : (rx_push && rx_full && !rx_pop) ? 1'b1 : ovf_q;
    brk_d = clr_errors ? 1'b0 : (rx_push && rsh_q == '0 && !cur) ? 1'b1 : brk_q;
  end

  assign rx_overflow = ovf_q;
  assign rx_break = brk_q;
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed + randomized loopback checks of uart_fifo in 8N1, 7E2 and 12O1 builds
module tb_uart_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_txd, a_rxd;
  logic a_dv, a_dr, a_rdv, a_rdr, a_pok, a_fok, a_ovf, a_brk, a_clr, a_rx, a_tx, a_sel, a_drv;
  logic [2:0] a_tl, a_rl;
  logic [6:0] b_txd, b_rxd;
  logic b_dv, b_dr, b_rdv, b_rdr, b_pok, b_fok, b_ovf, b_brk, b_tx;
  logic [2:0] b_tl, b_rl;
  logic [11:0] c_txd, c_rxd;
  logic c_dv, c_dr, c_rdv, c_rdr, c_pok, c_fok, c_ovf, c_brk, c_tx;
  logic [2:0] c_tl, c_rl;
  logic zero = 1'b0;

  assign a_rx = a_sel ? a_drv : a_tx;

  uart_fifo #(.CLK_FREQ(250), .BAUD_RATE(50), .NR_BITS(8), .PARITY("NONE"), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .uart_tx_d(a_txd), .uart_tx_dv(a_dv), .uart_tx_dr(a_dr),
    .uart_rx_d(a_rxd), .uart_rx_dv(a_rdv), .uart_rx_dr(a_rdr), .parity_ok(a_pok), .framing_ok(a_fok),
    .rx_overflow(a_ovf), .rx_break(a_brk), .clr_errors(a_clr), .tx_level(a_tl), .rx_level(a_rl),
    .uart_rx(a_rx), .uart_tx(a_tx)
  );
  uart_fifo #(.CLK_FREQ(250), .BAUD_RATE(50), .NR_BITS(7), .PARITY("EVEN"), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .uart_tx_d(b_txd), .uart_tx_dv(b_dv), .uart_tx_dr(b_dr),
    .uart_rx_d(b_rxd), .uart_rx_dv(b_rdv), .uart_rx_dr(b_rdr), .parity_ok(b_pok), .framing_ok(b_fok),
    .rx_overflow(b_ovf), .rx_break(b_brk), .clr_errors(zero), .tx_level(b_tl), .rx_level(b_rl),
    .uart_rx(b_tx), .uart_tx(b_tx)
  );
  uart_fifo #(.CLK_FREQ(250), .BAUD_RATE(50), .NR_BITS(12), .PARITY("ODD"), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .uart_tx_d(c_txd), .uart_tx_dv(c_dv), .uart_tx_dr(c_dr),
    .uart_rx_d(c_rxd), .uart_rx_dv(c_rdv), .uart_rx_dr(c_rdr), .parity_ok(c_pok), .framing_ok(c_fok),
    .rx_overflow(c_ovf), .rx_break(c_brk), .clr_errors(zero), .tx_level(c_tl), .rx_level(c_rl),
    .uart_rx(c_tx), .uart_tx(c_tx)
  );

  int checks = 0;
  int errors = 0;
  int lsel = 0;
  logic line;
  bit exp_bits[$];
  logic [15:0] wr_w[8];
  int wr_n;
  logic [7:0] mq[$];
  logic [7:0] ovw[6];

  always_comb line = lsel == 0 ? a_tx : lsel == 1 ? b_tx : c_tx;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference frame: start 0, data LSB first, optional parity, stop bits of 1
  task automatic add_frame(logic [15:0] w, int nb, int par, int stop);
    bit p = 1'b0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_bits.push_back(w[i]);
      p ^= w[i];
    end
    if (par == 2) p = ~p;
    if (par != 0) exp_bits.push_back(p);
    for (int i = 0; i < stop; i++) exp_bits.push_back(1'b1);
  endtask

  task automatic set_tx(int d, logic v, logic [15:0] w);
    if (d == 0) begin a_dv = v; a_txd = w[7:0]; end
    else if (d == 1) begin b_dv = v; b_txd = w[6:0]; end
    else begin c_dv = v; c_txd = w[11:0]; end
  endtask

  // writes wr_w[0..wr_n-1] on consecutive edges and checks every clock of the line
  task automatic tx_burst(string tag, int d);
    int n = 5 * exp_bits.size();
    lsel = d;
    set_tx(d, 1'b1, wr_w[0]);
    tick();
    for (int c = 0; c <= n + 2; c++) begin
      if (c + 1 < wr_n) set_tx(d, 1'b1, wr_w[c+1]);
      else if (c + 1 == wr_n) set_tx(d, 1'b0, 16'h0);
      chk(tag, line, (c < 2 || c >= n + 2) ? 1'b1 : exp_bits[(c-2)/5]);
      tick();
    end
    exp_bits.delete();
  endtask

  task automatic pop_a(string tag, logic [7:0] w, logic pok, logic fok);
    chk({tag, "_dv"}, a_rdv, 1'b1);
    chk({tag, "_d"}, a_rxd, w);
    chk({tag, "_pok"}, a_pok, pok);
    chk({tag, "_fok"}, a_fok, fok);
    a_rdr = 1'b1;
    tick();
    a_rdr = 1'b0;
  endtask

  task automatic tx_write_a(logic [7:0] w);
    int k = 0;
    a_txd = w;
    a_dv = 1'b1;
    while (!a_dr && k < 2000) begin
      tick();
      k++;
    end
    chk("tx_dr_wait", a_dr, 1'b1);
    tick();
    a_dv = 1'b0;
  endtask

  // drives one 8N1-shaped frame on uart_rx; gb>=0 inverts the middle clock of data bit gb
  task automatic drive_frame(logic [7:0] w, logic stopv, int gb, int hold_low);
    logic [9:0] f = {stopv, w, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 5; k++) begin
        a_drv = (i == gb + 1 && k == 2) ? ~f[i] : f[i];
        tick();
      end
    a_drv = 1'b0;
    repeat (hold_low) tick();
    a_drv = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got;
    logic [7:0] w, e;
    a_txd = '0; a_dv = 0; a_rdr = 0; a_clr = 0; a_sel = 0; a_drv = 1;
    b_txd = '0; b_dv = 0; b_rdr = 0; c_txd = '0; c_dv = 0; c_rdr = 0;
    repeat (3) tick();
    chk("rst_tx", a_tx, 1'b1);
    chk("rst_tx_dr", a_dr, 1'b1);
    chk("rst_rx_dv", a_rdv, 1'b0);
    chk("rst_rx_d", a_rxd, 8'h00);
    chk("rst_pok", a_pok, 1'b1);
    chk("rst_fok", a_fok, 1'b1);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_brk", a_brk, 1'b0);
    chk("rst_tl", a_tl, 3'd0);
    chk("rst_rl", a_rl, 3'd0);
    rst_n = 1'b1;
    tick();

    // back-to-back 8N1 frames, no idle gaps
    wr_w[0] = 16'h81; wr_w[1] = 16'h5A; wr_w[2] = 16'hA5; wr_w[3] = 16'h00; wr_n = 4;
    for (int i = 0; i < 4; i++) add_frame(wr_w[i], 8, 0, 1);
    tx_burst("t1_line", 0);
    repeat (5) tick();
    chk("t1_rl", a_rl, 3'd4);
    pop_a("t1_w0", 8'h81, 1, 1);
    pop_a("t1_w1", 8'h5A, 1, 1);
    pop_a("t1_w2", 8'hA5, 1, 1);
    pop_a("t1_w3", 8'h00, 1, 1);

    // random loopback traffic with random consumer backpressure
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 3000 && got < 16; cyc++) begin
      a_dv = sent < 16 && $urandom_range(0, 1) == 1;
      a_txd = 8'($urandom);
      if (a_dv && a_dr) begin
        mq.push_back(a_txd);
        sent++;
      end
      a_rdr = $urandom_range(0, 1) == 1;
      if (a_rdv && a_rdr) begin
        e = mq.pop_front();
        chk("rand_d", a_rxd, e);
        chk("rand_ok", {a_pok, a_fok}, 2'b11);
        got++;
      end
      tick();
    end
    a_dv = 0; a_rdr = 0;
    chk("rand_count", got, 16);
    chk("rand_ovf", a_ovf, 1'b0);

    // 7E2 and 12O1 frames
    wr_w[0] = 16'h41; wr_n = 1;
    add_frame(16'h41, 7, 1, 2);
    tx_burst("t2_7e2_line", 1);
    repeat (5) tick();
    chk("t2_b_rl", b_rl, 3'd1);
    chk("t2_b_d", b_rxd, 7'h41);
    chk("t2_b_ok", {b_pok, b_fok}, 2'b11);
    chk("t2_b_flags", {b_ovf, b_brk, b_dr, b_rdv, b_tl}, {2'b00, 2'b11, 3'd0});
    wr_w[0] = 16'hA5A;
    add_frame(16'hA5A, 12, 2, 1);
    tx_burst("t2_12o1_line", 2);
    repeat (5) tick();
    chk("t2_c_rl", c_rl, 3'd1);
    chk("t2_c_d", c_rxd, 12'hA5A);
    chk("t2_c_ok", {c_pok, c_fok}, 2'b11);
    chk("t2_c_flags", {c_ovf, c_brk, c_dr, c_rdv, c_tl}, {2'b00, 2'b11, 3'd0});
    lsel = 0;

    // RX overflow with the consumer stalled
    for (int i = 0; i < 6; i++) begin
      ovw[i] = 8'($urandom);
      tx_write_a(ovw[i]);
    end
    repeat (320) tick();
    chk("t3_rl", a_rl, 3'd4);
    chk("t3_tl", a_tl, 3'd0);
    chk("t3_ovf", a_ovf, 1'b1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("t3_ovf_clr", a_ovf, 1'b0);
    for (int i = 0; i < 4; i++) pop_a("t3_w", ovw[i], 1, 1);
    chk("t3_rl_empty", a_rl, 3'd0);

    // false start, then a break frame followed by a held-low line
    a_sel = 1'b1;
    a_drv = 1'b0;
    repeat (2) tick();
    a_drv = 1'b1;
    repeat (60) tick();
    chk("t4_false_start", a_rl, 3'd0);
    drive_frame(8'h00, 1'b0, -1, 30);
    repeat (60) tick();
    chk("t4_rl", a_rl, 3'd1);
    chk("t4_brk", a_brk, 1'b1);
    chk("t4_ovf", a_ovf, 1'b0);
    pop_a("t4_w", 8'h00, 1, 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("t4_brk_clr", a_brk, 1'b0);

    // single-clock mid-bit glitches are voted out
    for (int i = 0; i < 3; i++) begin
      ovw[i] = 8'($urandom);
      drive_frame(ovw[i], 1'b1, $urandom_range(0, 7), 0);
      repeat (3) tick();
    end
    repeat (10) tick();
    chk("t5_rl", a_rl, 3'd3);
    for (int i = 0; i < 3; i++) pop_a("t5_w", ovw[i], 1, 1);
    chk("t5_brk", a_brk, 1'b0);

    // reset in the middle of a frame
    a_sel = 1'b0;
    a_txd = 8'h00;
    a_dv = 1'b1;
    repeat (3) tick();
    a_dv = 1'b0;
    repeat (15) tick();
    chk("t6_mid_frame", a_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", a_tx, 1'b1);
    chk("t6_rst_tl", a_tl, 3'd0);
    chk("t6_rst_dr", a_dr, 1'b1);
    chk("t6_rst_rdv", a_rdv, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    w = 8'h3C;
    wr_w[0] = {8'h00, w}; wr_n = 1;
    add_frame(wr_w[0], 8, 0, 1);
    tx_burst("t6_line", 0);
    repeat (5) tick();
    chk("t6_rl", a_rl, 3'd1);
    pop_a("t6_w", 8'h3C, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
